// File: rtl/red_pitaya_pwm_ramp.sv
// Frame-synchronous setpoint ramp generator for a PWM: a small FIFO of
// {target, dwell} segments is slewed toward at step_i per frame, then held.
module red_pitaya_pwm_ramp #(
    parameter int CCW   = 24,
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [CCW-1:0] tgt_i,
    input  logic [DW-1:0]  dwell_i,
    input  logic           tgt_valid_i,
    output logic           tgt_ready_o,
    input  logic [CCW-1:0] step_i,
    input  logic           hold_i,
    input  logic           clear_i,
    input  logic           pwm_s_i,
    output logic [CCW-1:0] cfg_o,
    output logic           busy_o,
    output logic           seg_done_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CCW + DW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RAMP, DWELL} state_t;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [AW:0]    count_reg, count_next;
    logic           ready_reg;

    state_t         state_reg, state_next;
    logic [CCW-1:0] cfg_reg, cfg_next;
    logic [CCW-1:0] cur_tgt_reg, cur_tgt_next;
    logic [DW-1:0]  cur_dwell_reg, cur_dwell_next;
    logic [DW-1:0]  dwell_cnt_reg, dwell_cnt_next;
    logic           seg_done_reg, seg_done_next;

    logic           push, pop, empty, frame;
    logic [CCW-1:0] head_tgt;
    logic [DW-1:0]  head_dwell;
    logic [CCW:0]   sum, diff;
    logic [CCW-1:0] ramp_val;

    assign {head_tgt, head_dwell} = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign frame = pwm_s_i & ~hold_i & ~clear_i;

    // A pop on the same edge frees a slot, so a push is taken even when full.
    assign push = rstn & tgt_valid_i & ~clear_i & (ready_reg | pop);

    // One extra bit keeps the slew from wrapping at either end of the range.
    assign sum  = {1'b0, cfg_reg} + {1'b0, step_i};
    assign diff = {1'b0, cfg_reg} - {1'b0, step_i};

    always_comb begin
        ramp_val = cur_tgt_reg;
        if (cfg_reg < cur_tgt_reg) begin
            if ((step_i != '0) && (sum < {1'b0, cur_tgt_reg}))
                ramp_val = sum[CCW-1:0];
        end else if (cfg_reg > cur_tgt_reg) begin
            if ((step_i != '0) && !diff[CCW] && (diff[CCW-1:0] > cur_tgt_reg))
                ramp_val = diff[CCW-1:0];
        end
    end

    always_comb begin
        state_next     = state_reg;
        cfg_next       = cfg_reg;
        cur_tgt_next   = cur_tgt_reg;
        cur_dwell_next = cur_dwell_reg;
        dwell_cnt_next = dwell_cnt_reg;
        seg_done_next  = 1'b0;
        pop            = 1'b0;
        if (clear_i) begin
            state_next = IDLE;
        end else if (frame) begin
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        pop            = 1'b1;
                        cur_tgt_next   = head_tgt;
                        cur_dwell_next = head_dwell;
                        state_next     = RAMP;
                    end
                end
                RAMP: begin
                    cfg_next = ramp_val;
                    if (ramp_val == cur_tgt_reg) begin
                        state_next     = DWELL;
                        dwell_cnt_next = cur_dwell_reg;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_reg != '0) begin
                        dwell_cnt_next = dwell_cnt_reg - 1'b1;
                    end else begin
                        seg_done_next = 1'b1;
                        if (!empty) begin
                            pop            = 1'b1;
                            cur_tgt_next   = head_tgt;
                            cur_dwell_next = head_dwell;
                            state_next     = RAMP;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + AW'(push);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        count_next  = count_reg + (AW+1)'(push) - (AW+1)'(pop);
        if (clear_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {tgt_i, dwell_i};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cfg_reg       <= '0;
            cur_tgt_reg   <= '0;
            cur_dwell_reg <= '0;
            dwell_cnt_reg <= '0;
            seg_done_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cfg_reg       <= cfg_next;
            cur_tgt_reg   <= cur_tgt_next;
            cur_dwell_reg <= cur_dwell_next;
            dwell_cnt_reg <= dwell_cnt_next;
            seg_done_reg  <= seg_done_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            ready_reg     <= (count_next != FULL_CNT);
        end
    end

    assign tgt_ready_o = ready_reg;
    assign cfg_o       = cfg_reg;
    assign busy_o      = (state_reg != IDLE);
    assign seg_done_o  = seg_done_reg;

endmodule

// File: tb/tb_red_pitaya_pwm_ramp.sv
// Scoreboard bench for red_pitaya_pwm_ramp: stimulus queues expected outputs,
// the monitor compares them one edge later.
module tb_red_pitaya_pwm_ramp;
    localparam int CCW   = 24;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [CCW-1:0] tgt_i = '0;
    logic [DW-1:0]  dwell_i = '0;
    logic           tgt_valid_i = 1'b0;
    logic           tgt_ready_o;
    logic [CCW-1:0] step_i = '0;
    logic           hold_i = 1'b0;
    logic           clear_i = 1'b0;
    logic           pwm_s_i = 1'b0;
    logic [CCW-1:0] cfg_o;
    logic           busy_o;
    logic           seg_done_o;

    typedef struct {
        logic [CCW-1:0] cfg;
        logic           done;
        logic           busy;
        logic           rdy;
        string          name;
    } exp_t;

    exp_t sb[$];
    logic strobe = 1'b0;
    logic sampled = 1'b0;
    logic end_req = 1'b0;
    int   total = 0;
    int   bad = 0;

    red_pitaya_pwm_ramp #(.CCW(CCW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .tgt_i(tgt_i), .dwell_i(dwell_i),
        .tgt_valid_i(tgt_valid_i), .tgt_ready_o(tgt_ready_o), .step_i(step_i),
        .hold_i(hold_i), .clear_i(clear_i), .pwm_s_i(pwm_s_i), .cfg_o(cfg_o),
        .busy_o(busy_o), .seg_done_o(seg_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sampled <= strobe;

    always @(negedge clk) begin
        exp_t e;
        if (sampled) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got cfg=%h with empty queue, want no output", cfg_o);
            end else begin
                e = sb.pop_front();
                if (cfg_o !== e.cfg || seg_done_o !== e.done || busy_o !== e.busy || tgt_ready_o !== e.rdy) begin
                    bad++;
                    $display("FAIL %s: got cfg=%h done=%b busy=%b rdy=%b, want cfg=%h done=%b busy=%b rdy=%b",
                             e.name, cfg_o, seg_done_o, busy_o, tgt_ready_o, e.cfg, e.done, e.busy, e.rdy);
                end else begin
                    $display("ok   %s: cfg=%h done=%b busy=%b rdy=%b", e.name, cfg_o, seg_done_o, busy_o, tgt_ready_o);
                end
            end
        end
        if (end_req) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL leftover: pending=%0d, want 0", sb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic f, input logic [CCW-1:0] ecfg, input logic edone,
                        input logic ebusy, input logic erdy, input string nm);
        exp_t e;
        e.cfg = ecfg; e.done = edone; e.busy = ebusy; e.rdy = erdy; e.name = nm;
        sb.push_back(e);
        pwm_s_i = f;
        strobe  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pwm_s_i = 1'b0;
        strobe  = 1'b0;
    endtask

    task automatic fr(input logic [CCW-1:0] ecfg, input logic edone, input logic ebusy,
                      input logic erdy, input string nm);
        tick(1'b1, ecfg, edone, ebusy, erdy, nm);
    endtask

    task automatic push(input logic [CCW-1:0] t, input logic [DW-1:0] d, input logic [CCW-1:0] ecfg,
                        input logic ebusy, input logic erdy, input string nm);
        tgt_i = t; dwell_i = d; tgt_valid_i = 1'b1;
        tick(1'b0, ecfg, 1'b0, ebusy, erdy, nm);
        tgt_valid_i = 1'b0;
    endtask

    initial begin
        // reset state and release
        tick(0, 24'h0, 0, 0, 0, "rst_a");
        tick(1, 24'h0, 0, 0, 0, "rst_b");
        rstn = 1'b1;
        tick(0, 24'h0, 0, 0, 1, "rst_release");

        // ramp up 0 -> 0x100 in 0x40 steps, dwell 2
        step_i = 24'h40;
        push(24'h000100, 16'd2, 24'h0, 0, 1, "up_push");
        fr(24'h000000, 0, 1, 1, "up_pop");
        fr(24'h000040, 0, 1, 1, "up_1");
        tick(0, 24'h000040, 0, 1, 1, "up_stable");
        fr(24'h000080, 0, 1, 1, "up_2");
        fr(24'h0000C0, 0, 1, 1, "up_3");
        fr(24'h000100, 0, 1, 1, "up_4");
        fr(24'h000100, 0, 1, 1, "up_dw1");
        fr(24'h000100, 0, 1, 1, "up_dw0");
        fr(24'h000100, 1, 0, 1, "up_done");
        tick(0, 24'h000100, 0, 0, 1, "up_idle");

        // clamp at all-ones, then down-ramp clamped at zero
        step_i = 24'h0;
        push(24'hFFFF00, 16'd0, 24'h000100, 0, 1, "jump_push");
        fr(24'h000100, 0, 1, 1, "jump_pop");
        fr(24'hFFFF00, 0, 1, 1, "jump_step0");
        fr(24'hFFFF00, 1, 0, 1, "jump_done");
        step_i = 24'h80;
        push(24'hFFFFFF, 16'd0, 24'hFFFF00, 0, 1, "hi_push");
        fr(24'hFFFF00, 0, 1, 1, "hi_pop");
        fr(24'hFFFF80, 0, 1, 1, "hi_1");
        fr(24'hFFFFFF, 0, 1, 1, "hi_clamp");
        push(24'h000000, 16'd0, 24'hFFFFFF, 1, 1, "lo_push");
        step_i = 24'h800000;
        fr(24'hFFFFFF, 1, 1, 1, "hi_done_lo_pop");
        fr(24'h7FFFFF, 0, 1, 1, "lo_1");
        fr(24'h000000, 0, 1, 1, "lo_clamp");
        fr(24'h000000, 1, 0, 1, "lo_done");

        // FIFO full: 5th push dropped, push alongside a pop at full is kept
        step_i = 24'h10;
        push(24'h10, 16'd0, 24'h0, 0, 1, "full_p1");
        push(24'h20, 16'd0, 24'h0, 0, 1, "full_p2");
        push(24'h30, 16'd0, 24'h0, 0, 1, "full_p3");
        push(24'h40, 16'd0, 24'h0, 0, 0, "full_p4");
        push(24'h50, 16'd0, 24'h0, 0, 0, "full_p5_drop");
        tgt_i = 24'h60; dwell_i = 16'd0; tgt_valid_i = 1'b1;
        fr(24'h0, 0, 1, 0, "full_pop_push");
        tgt_valid_i = 1'b0;
        fr(24'h10, 0, 1, 0, "drain_a");
        fr(24'h10, 1, 1, 1, "drain_a_done");
        fr(24'h20, 0, 1, 1, "drain_b");
        fr(24'h20, 1, 1, 1, "drain_b_done");
        fr(24'h30, 0, 1, 1, "drain_c");
        fr(24'h30, 1, 1, 1, "drain_c_done");
        fr(24'h40, 0, 1, 1, "drain_d");
        fr(24'h40, 1, 1, 1, "drain_d_done");
        fr(24'h50, 0, 1, 1, "drain_f_mid");
        fr(24'h60, 0, 1, 1, "drain_f");
        fr(24'h60, 1, 0, 1, "drain_f_done");

        // hold mid-ramp and mid-dwell; pushes still accepted under hold
        step_i = 24'h40;
        push(24'h160, 16'd1, 24'h60, 0, 1, "hold_push");
        fr(24'h060, 0, 1, 1, "hold_pop");
        fr(24'h0A0, 0, 1, 1, "hold_r1");
        hold_i = 1'b1;
        fr(24'h0A0, 0, 1, 1, "hold_f1");
        fr(24'h0A0, 0, 1, 1, "hold_f2");
        fr(24'h0A0, 0, 1, 1, "hold_f3");
        hold_i = 1'b0;
        fr(24'h0E0, 0, 1, 1, "hold_resume");
        fr(24'h120, 0, 1, 1, "hold_r3");
        fr(24'h160, 0, 1, 1, "hold_reach");
        hold_i = 1'b1;
        fr(24'h160, 0, 1, 1, "hold_dw_f1");
        push(24'h160, 16'd0, 24'h160, 1, 1, "hold_push2");
        fr(24'h160, 0, 1, 1, "hold_dw_f2");
        hold_i = 1'b0;
        fr(24'h160, 0, 1, 1, "hold_dw0");
        fr(24'h160, 1, 1, 1, "hold_done_pop");
        fr(24'h160, 0, 1, 1, "seg2_reach");
        fr(24'h160, 1, 0, 1, "seg2_done");

        // clear during dwell with 2 queued; clear beats push and done
        push(24'h1A0, 16'd1, 24'h160, 0, 1, "clr_p1");
        push(24'h200, 16'd0, 24'h160, 0, 1, "clr_p2");
        push(24'h240, 16'd0, 24'h160, 0, 1, "clr_p3");
        fr(24'h160, 0, 1, 1, "clr_pop");
        fr(24'h1A0, 0, 1, 1, "clr_reach");
        fr(24'h1A0, 0, 1, 1, "clr_dw0");
        clear_i = 1'b1; tgt_i = 24'h300; dwell_i = 16'd0; tgt_valid_i = 1'b1;
        fr(24'h1A0, 0, 0, 1, "clr_pulse");
        clear_i = 1'b0; tgt_valid_i = 1'b0;
        fr(24'h1A0, 0, 0, 1, "clr_idle1");
        fr(24'h1A0, 0, 0, 1, "clr_idle2");

        // reset mid-ramp abandons segment and queue
        push(24'h300, 16'd0, 24'h1A0, 0, 1, "rr_push");
        fr(24'h1A0, 0, 1, 1, "rr_pop");
        fr(24'h1E0, 0, 1, 1, "rr_1");
        push(24'h400, 16'd0, 24'h1E0, 1, 1, "rr_push2");
        rstn = 1'b0;
        tick(0, 24'h0, 0, 0, 0, "rr_rst_a");
        fr(24'h0, 0, 0, 0, "rr_rst_b");
        rstn = 1'b1;
        tick(0, 24'h0, 0, 0, 1, "rr_release");
        fr(24'h0, 0, 0, 1, "rr_idle");

        @(negedge clk);
        end_req = 1'b1;
    end

endmodule
